// File: rtl/mic_pkg.sv
// mic_pkg
// Shared definitions for the microphone ADC front end.
//   state_t    : sequencer states (IDLE, SHIFT, DONE)
//   FRAME_BITS : SCLK rising edges per read frame
//   LEAD_ZEROS : leading bits the ADC sends ahead of the conversion result
//   SAMPLE_W   : width of the conversion result
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int SAMPLE_W   = 12;

endpackage

// File: rtl/mic_sampler_tick_gen.sv
// tick_gen
// Free-running modulo-DIV counter with a one-cycle tick on its last count.
// Ports:
//   clk  in  : clock
//   rst  in  : asynchronous active-high reset, clears the counter
//   tick out : high for the one cycle in which the counter holds DIV-1
module tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Counter wraps at DIV-1 and never stops, so ticks stay evenly spaced
    // whatever the consumer is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/mic_sampler.sv
// mic_sampler
// Runs one 16-clock SPI read frame on the Pmod mic ADC every SAMPLE_DIV
// clocks and presents the 12-bit result with a one-cycle valid strobe.
// Ports:
//   CLK          in  : system clock
//   RESET        in  : asynchronous active-high reset
//   J_MIC_DATA   in  : ADC serial data (MISO)
//   J_MIC_CS     out : ADC chip select, active low
//   J_MIC_SCLK   out : ADC serial clock, idles high
//   sample       out : last completed conversion (unsigned)
//   sample_valid out : one-cycle pulse when sample updates
//   frame_err    out : pulse with sample_valid when a leading bit read 1
module mic_sampler
    import mic_pkg::*;
#(
    parameter int SAMPLE_DIV = 5000,
    parameter int SCLK_HALF  = 5
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                J_MIC_DATA,
    output logic                J_MIC_CS,
    output logic                J_MIC_SCLK,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                frame_err
);

    // Half-period slot 0 is the CS-to-first-fall setup time; slots 1..32
    // are the 32 SCLK half-periods, so the last slot index is 2*FRAME_BITS.
    localparam logic [5:0] H_LAST = 6'(SCLK_HALF - 1);
    localparam logic [5:0] P_LAST = 6'(2 * FRAME_BITS);

    state_t                state;
    logic [5:0]            h;
    logic [5:0]            p;
    logic [FRAME_BITS-1:0] shreg;
    logic                  data_q;
    logic                  tick;

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (CLK),
        .rst  (RESET),
        .tick (tick)
    );

    // Sequencer. SCLK is registered and takes the level of the slot being
    // entered: odd slots low, even slots high. Entering an even slot is a
    // rising edge, which is when the registered MISO bit is shifted in.
    // A tick that arrives outside IDLE is simply ignored.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            h            <= '0;
            p            <= '0;
            shreg        <= '0;
            data_q       <= 1'b0;
            J_MIC_CS     <= 1'b1;
            J_MIC_SCLK   <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            data_q       <= J_MIC_DATA;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    J_MIC_CS   <= 1'b1;
                    J_MIC_SCLK <= 1'b1;
                    if (tick) begin
                        state    <= SHIFT;
                        J_MIC_CS <= 1'b0;
                        h        <= '0;
                        p        <= '0;
                    end
                end
                SHIFT: begin
                    if (h == H_LAST) begin
                        h <= '0;
                        if (p == P_LAST) begin
                            state        <= DONE;
                            p            <= '0;
                            J_MIC_CS     <= 1'b1;
                            J_MIC_SCLK   <= 1'b1;
                            sample       <= shreg[SAMPLE_W-1:0];
                            sample_valid <= 1'b1;
                            frame_err    <= |shreg[FRAME_BITS-1 -: LEAD_ZEROS];
                        end else begin
                            p          <= p + 6'd1;
                            J_MIC_SCLK <= p[0];
                            if (p[0]) begin
                                shreg <= {shreg[FRAME_BITS-2:0], data_q};
                            end
                        end
                    end else begin
                        h <= h + 6'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_sampler.sv
// tb_mic_sampler
// Directed bench for mic_sampler: one instance with default parameters and
// one with SCLK_HALF=4, SAMPLE_DIV=200, each fed by a simple ADC model that
// drives the next frame bit (MSB first) on every SCLK fall while CS is low.
module tb_mic_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miso = 1'b0;
    logic        cs;
    logic        sclk;
    logic [11:0] sample;
    logic        valid;
    logic        ferr;

    logic        rst4 = 1'b1;
    logic        miso4 = 1'b0;
    logic        cs4;
    logic        sclk4;
    logic [11:0] sample4;
    logic        valid4;
    logic        ferr4;

    logic [15:0] adc_word  = 16'h0AC3;
    logic [3:0]  adc_idx   = 4'd0;
    logic [15:0] adc_word4 = 16'h0000;
    logic [3:0]  adc_idx4  = 4'd0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int rel = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mic_sampler dut (
        .CLK          (clk),
        .RESET        (rst),
        .J_MIC_DATA   (miso),
        .J_MIC_CS     (cs),
        .J_MIC_SCLK   (sclk),
        .sample       (sample),
        .sample_valid (valid),
        .frame_err    (ferr)
    );

    mic_sampler #(
        .SAMPLE_DIV (200),
        .SCLK_HALF  (4)
    ) dut4 (
        .CLK          (clk),
        .RESET        (rst4),
        .J_MIC_DATA   (miso4),
        .J_MIC_CS     (cs4),
        .J_MIC_SCLK   (sclk4),
        .sample       (sample4),
        .sample_valid (valid4),
        .frame_err    (ferr4)
    );

    // ADC models: bit index restarts whenever CS is high.
    always @(negedge sclk or posedge cs) begin
        if (cs) begin
            adc_idx = 4'd0;
        end else begin
            miso    = adc_word[4'd15 - adc_idx];
            adc_idx = adc_idx + 4'd1;
        end
    end

    always @(negedge sclk4 or posedge cs4) begin
        if (cs4) begin
            adc_idx4 = 4'd0;
        end else begin
            miso4    = adc_word4[4'd15 - adc_idx4];
            adc_idx4 = adc_idx4 + 4'd1;
        end
    end

    // Waits (bounded) for sample_valid on the default instance.
    task automatic wait_valid(input int budget, output int at, output bit got);
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                at  = cyc - rel;
                break;
            end
        end
    endtask

    // Waits (bounded) for CS low, counting any valid pulses seen meanwhile.
    task automatic wait_cs_low(input int budget, output int at, output bit got,
                               output int valid_seen);
        got        = 1'b0;
        at         = 0;
        valid_seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid) valid_seen++;
            if (!cs) begin
                got = 1'b1;
                at  = cyc - rel;
                break;
            end
        end
    endtask

    task automatic test_reset;
        adc_word = 16'h0AC3;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1)     begin failures++; $display("[TB] FAIL reset_cs: got %b expected 1", cs); end
        checks++; if (sclk !== 1'b1)   begin failures++; $display("[TB] FAIL reset_sclk: got %b expected 1", sclk); end
        checks++; if (sample !== 12'h000) begin failures++; $display("[TB] FAIL reset_sample: got %h expected 000", sample); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (ferr !== 1'b0)   begin failures++; $display("[TB] FAIL reset_ferr: got %b expected 0", ferr); end
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic test_single_frame;
        int at;
        bit got;
        int vs;
        wait_cs_low(5100, at, got, vs);
        checks++; if (!got || at != 5000) begin failures++; $display("[TB] FAIL first_cs_fall: got %0d (seen %b) expected 5000", at, got); end
        checks++; if (vs != 0) begin failures++; $display("[TB] FAIL early_valid: got %0d pulses expected 0", vs); end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sclk) begin got = 1'b1; at = cyc - rel; break; end
        end
        checks++; if (!got || at != 5005) begin failures++; $display("[TB] FAIL first_sclk_fall: got %0d expected 5005", at); end
        wait_valid(400, at, got);
        checks++; if (!got || at != 5165) begin failures++; $display("[TB] FAIL frame1_valid_time: got %0d expected 5165", at); end
        checks++; if (sample !== 12'hAC3) begin failures++; $display("[TB] FAIL frame1_sample: got %h expected ac3", sample); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("[TB] FAIL frame1_ferr: got %b expected 0", ferr); end
        checks++; if (cs !== 1'b1) begin failures++; $display("[TB] FAIL frame1_cs_done: got %b expected 1", cs); end
        adc_word = 16'h0FFF;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL frame1_pulse_width: got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back;
        int at;
        int v1;
        int v2;
        bit got;
        int vs;
        wait_cs_low(5000, at, got, vs);
        checks++; if (!got || at != 10000) begin failures++; $display("[TB] FAIL b2b_cs_fall: got %0d expected 10000", at); end
        checks++; if (sample !== 12'hAC3) begin failures++; $display("[TB] FAIL b2b_sample_hold: got %h expected ac3", sample); end
        wait_valid(400, v1, got);
        checks++; if (!got || v1 != 10165) begin failures++; $display("[TB] FAIL b2b_valid1_time: got %0d expected 10165", v1); end
        checks++; if (sample !== 12'hFFF) begin failures++; $display("[TB] FAIL b2b_sample1: got %h expected fff", sample); end
        adc_word = 16'h0000;
        wait_cs_low(5000, at, got, vs);
        checks++; if (!got || at != 15000) begin failures++; $display("[TB] FAIL b2b_cs_fall2: got %0d expected 15000", at); end
        wait_valid(400, v2, got);
        checks++; if (!got || (v2 - v1) != 5000) begin failures++; $display("[TB] FAIL b2b_interval: got %0d expected 5000", v2 - v1); end
        checks++; if (sample !== 12'h000) begin failures++; $display("[TB] FAIL b2b_sample2: got %h expected 000", sample); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ferr2: got %b expected 0", ferr); end
        adc_word = 16'h4123;
    endtask

    task automatic test_frame_err;
        int at;
        bit got;
        wait_valid(5200, at, got);
        checks++; if (!got || at != 20165) begin failures++; $display("[TB] FAIL ferr_valid_time: got %0d expected 20165", at); end
        checks++; if (sample !== 12'h123) begin failures++; $display("[TB] FAIL ferr_sample: got %h expected 123", sample); end
        checks++; if (ferr !== 1'b1) begin failures++; $display("[TB] FAIL ferr_flag: got %b expected 1", ferr); end
        @(negedge clk);
        checks++; if (ferr !== 1'b0) begin failures++; $display("[TB] FAIL ferr_pulse_width: got %b expected 0", ferr); end
        adc_word = 16'h0AC3;
    endtask

    task automatic test_reset_mid_frame;
        int at;
        bit got;
        int vs;
        wait_cs_low(5000, at, got, vs);
        checks++; if (!got || at != 25000) begin failures++; $display("[TB] FAIL mid_cs_fall: got %0d expected 25000", at); end
        repeat (105) @(negedge clk);
        checks++; if (cs !== 1'b0) begin failures++; $display("[TB] FAIL mid_in_frame: got cs=%b expected 0", cs); end
        #1 rst = 1'b1;
        #1;
        checks++; if (cs !== 1'b1)     begin failures++; $display("[TB] FAIL mid_cs_async: got %b expected 1", cs); end
        checks++; if (sclk !== 1'b1)   begin failures++; $display("[TB] FAIL mid_sclk_async: got %b expected 1", sclk); end
        checks++; if (sample !== 12'h000) begin failures++; $display("[TB] FAIL mid_sample_clear: got %h expected 000", sample); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("[TB] FAIL mid_valid: got %b expected 0", valid); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        wait_cs_low(5100, at, got, vs);
        checks++; if (!got || at != 5000) begin failures++; $display("[TB] FAIL post_reset_cs_fall: got %0d expected 5000", at); end
        checks++; if (vs != 0) begin failures++; $display("[TB] FAIL post_reset_valid: got %0d pulses expected 0", vs); end
        checks++; if (sample !== 12'h000) begin failures++; $display("[TB] FAIL post_reset_sample: got %h expected 000", sample); end
        wait_valid(400, at, got);
        checks++; if (!got || at != 5165) begin failures++; $display("[TB] FAIL post_reset_valid_time: got %0d expected 5165", at); end
        checks++; if (sample !== 12'hAC3) begin failures++; $display("[TB] FAIL post_reset_sample2: got %h expected ac3", sample); end
    endtask

    // 100 frames on the fast instance with a cycle-by-cycle protocol check.
    task automatic test_protocol;
        int          rel4;
        int          frames = 0;
        int          windows = 0;
        int          run = 0;
        int          rises = 0;
        logic        prev_cs = 1'b1;
        logic        prev_sclk = 1'b1;
        logic [11:0] expv;
        logic [11:0] kk;
        expv      = 12'h5A7;
        adc_word4 = {4'h0, expv};
        @(negedge clk);
        rst4 = 1'b0;
        rel4 = cyc;
        for (int c = 0; c < 20400 && frames < 100; c++) begin
            @(negedge clk);
            if (cs4) begin
                checks++; if (sclk4 !== 1'b1) begin failures++; $display("[TB] FAIL proto_sclk_idle: got %b expected 1 at %0d", sclk4, cyc - rel4); end
                if (!prev_cs) begin
                    windows++;
                    checks++; if (run != 4) begin failures++; $display("[TB] FAIL proto_last_half: got %0d expected 4", run); end
                    checks++; if (rises != 16) begin failures++; $display("[TB] FAIL proto_rise_count: got %0d expected 16", rises); end
                end
            end else begin
                if (prev_cs) begin
                    run   = 1;
                    rises = 0;
                end else if (sclk4 !== prev_sclk) begin
                    checks++; if (run != 4) begin failures++; $display("[TB] FAIL proto_half_period: got %0d expected 4", run); end
                    if (sclk4) rises++;
                    run = 1;
                end else begin
                    run++;
                end
            end
            if (valid4) begin
                checks++; if ((cyc - rel4) != 332 + 200 * frames) begin failures++; $display("[TB] FAIL proto_valid_time: got %0d expected %0d", cyc - rel4, 332 + 200 * frames); end
                checks++; if (sample4 !== expv) begin failures++; $display("[TB] FAIL proto_sample: got %h expected %h", sample4, expv); end
                checks++; if (ferr4 !== 1'b0) begin failures++; $display("[TB] FAIL proto_ferr: got %b expected 0", ferr4); end
                frames++;
                kk        = 12'(frames * 37);
                expv      = 12'h5A7 ^ kk;
                adc_word4 = {4'h0, expv};
            end
            prev_cs   = cs4;
            prev_sclk = sclk4;
        end
        checks++; if (frames != 100) begin failures++; $display("[TB] FAIL proto_frames: got %0d expected 100", frames); end
        checks++; if (windows != 100) begin failures++; $display("[TB] FAIL proto_windows: got %0d expected 100", windows); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_frame_err;
        test_reset_mid_frame;
        test_protocol;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
